// File: rtl/serial_ctrl_shifter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : serial_ctrl_shifter_pkg
//  Brief   : Shared types for the serial control-word shifter (FSM states,
//            gap counter width).
//  Revision: 1.0 - initial release
// ============================================================================
package serial_ctrl_shifter_pkg;

  // Frame sequencer states; encoding is fixed at 3 bits.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Width of the post-latch idle counter (GAP_TICKS range 0..15).
  localparam int GAPCNT_W = 4;

endpackage : serial_ctrl_shifter_pkg
`default_nettype wire

// File: rtl/serial_ctrl_shifter_edge.sv
`default_nettype none
// ============================================================================
//  Module  : div_edge_detect
//  Brief   : One-cycle rise/fall strobes for the divider's slow clock, which
//            is already registered in the master clock domain.
//  Revision: 1.0 - initial release
// ============================================================================
module div_edge_detect (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic div_q;

  // Hold the previous sample of the slow clock to compare against.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q <= 1'b0;
    end else begin
      div_q <= d_i;
    end
  end

  assign rise_o = d_i & ~div_q;
  assign fall_o = ~d_i & div_q;

endmodule : div_edge_detect
`default_nettype wire

// File: rtl/serial_ctrl_shifter.sv
`default_nettype none
// ============================================================================
//  Module  : serial_ctrl_shifter
//  Brief   : Serialises one WIDTH-bit control word per request onto
//            sclk_o/sdata_o, clocked by falling edges of the divider clock,
//            then issues a one-period latch_o strobe and an optional gap.
//  Revision: 1.0 - initial release
// ============================================================================
module serial_ctrl_shifter
  import serial_ctrl_shifter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP_TICKS = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             div_clk_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             sclk_o,
  output logic             sdata_o,
  output logic             latch_o
);

  localparam int                   BITCNT_W    = $clog2(WIDTH);
  localparam logic [BITCNT_W-1:0]  BITCNT_LAST = BITCNT_W'(WIDTH - 1);
  localparam logic [GAPCNT_W-1:0]  GAP_INIT    = GAPCNT_W'(GAP_TICKS);

  state_e                state_q,  state_d;
  logic [WIDTH-1:0]      shreg_q,  shreg_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [GAPCNT_W-1:0]   gapcnt_q, gapcnt_d;
  logic                  busy_q,   busy_d;
  logic                  sclk_q,   sclk_d;
  logic                  sdata_q,  sdata_d;
  logic                  latch_q,  latch_d;

  logic                  div_rise, div_fall;
  logic                  head_bit, next_bit;
  logic [WIDTH-1:0]      shreg_shifted;

  div_edge_detect u_edge (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (div_clk_i),
    .rise_o  (div_rise),
    .fall_o  (div_fall)
  );

  // Bit order selects which end of the shift register feeds sdata.
  if (MSB_FIRST) begin : g_msb_first
    assign head_bit      = shreg_q[WIDTH-1];
    assign next_bit      = shreg_q[WIDTH-2];
    assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
  end else begin : g_lsb_first
    assign head_bit      = shreg_q[0];
    assign next_bit      = shreg_q[1];
    assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
  end

  // Next-state and output decode; only a div_clk fall advances the frame.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    busy_d   = busy_q;
    sclk_d   = 1'b0;
    sdata_d  = sdata_q;
    latch_d  = latch_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          shreg_d  = data_i;
          bitcnt_d = BITCNT_LAST;
          busy_d   = 1'b1;
          state_d  = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (div_fall) begin
          sdata_d = head_bit;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sclk_d = div_clk_i;
        if (div_fall) begin
          if (bitcnt_q != '0) begin
            shreg_d  = shreg_shifted;
            bitcnt_d = bitcnt_q - 1'b1;
            sdata_d  = next_bit;
          end else begin
            sdata_d = 1'b0;
            sclk_d  = 1'b0;
            latch_d = 1'b1;
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (div_fall) begin
          latch_d  = 1'b0;
          gapcnt_d = GAP_INIT;
          if (GAP_TICKS == 0) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (div_fall) begin
          gapcnt_d = gapcnt_q - 1'b1;
          if (gapcnt_q == GAPCNT_W'(1)) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        sdata_d = 1'b0;
        latch_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      busy_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      latch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      busy_q   <= busy_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      latch_q  <= latch_d;
    end
  end

  // The rise strobe is only observed here: both strobes can never fire together.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (!(div_rise && div_fall));
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign busy_o  = busy_q;
  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;
  assign latch_o = latch_q;

endmodule : serial_ctrl_shifter
`default_nettype wire

// File: tb/tb_serial_ctrl_shifter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_serial_ctrl_shifter
//  Brief   : Self-checking bench: two shifter instances (MSB-first with a
//            one-period gap, LSB-first with no gap) driven by a 125x divider.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_serial_ctrl_shifter;

  localparam int PERIOD    = 125;
  localparam int LOW_CYC   = 63;
  localparam int FRAME_TMO = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_clk = 1'b0;
  logic        stall = 1'b0;
  int          div_cnt = 0;
  longint      cyc = 0;

  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic        ready_a, busy_a, sclk_a, sdata_a, latch_a;
  logic        ready_b, busy_b, sclk_b, sdata_b, latch_b;

  int checks = 0;
  int errors = 0;

  serial_ctrl_shifter #(.WIDTH(16), .MSB_FIRST(1'b1), .GAP_TICKS(1)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .div_clk_i(div_clk), .data_i(data_a), .valid_i(valid_a),
    .ready_o(ready_a), .busy_o(busy_a), .sclk_o(sclk_a), .sdata_o(sdata_a), .latch_o(latch_a));

  serial_ctrl_shifter #(.WIDTH(16), .MSB_FIRST(1'b0), .GAP_TICKS(0)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .div_clk_i(div_clk), .data_i(data_b), .valid_i(valid_b),
    .ready_o(ready_b), .busy_o(busy_b), .sclk_o(sclk_b), .sdata_o(sdata_b), .latch_o(latch_b));

  always #5 clk = ~clk;

  // Divider stand-in: low 63, high 62 master cycles; stall pins it low.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stall) begin
      div_clk <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == PERIOD - 1) ? 0 : div_cnt + 1;
      div_clk <= (((div_cnt == PERIOD - 1) ? 0 : div_cnt + 1) >= LOW_CYC);
    end
  end

  // Reference model: every accepted request is a word that must appear on the wire.
  logic [15:0] exp_a[$], exp_b[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (valid_a && ready_a) exp_a.push_back(data_a);
      if (valid_b && ready_b) exp_b.push_back(data_b);
    end
  end

  typedef struct {
    logic [15:0] word;
    int          rises;
    int          llen;
    int          falls;
    logic        busy_end;
    logic        first;
    longint      t_rise;
  } frame_t;

  frame_t got_a[$], got_b[$];
  frame_t cur_a, cur_b;
  logic   pdiv_a = 0, ps_a = 0, pl_a = 0, pb_a = 0;
  logic   pdiv_b = 0, ps_b = 0, pl_b = 0, pb_b = 0;
  int     rises_a = 0, falls_a = 0, tot_rise_a = 0, tot_latch_a = 0;
  int     rises_b = 0, falls_b = 0;
  logic [15:0] w_a = '0, w_b = '0;

  // Wire-level receiver for instance A: samples sdata on sclk rise, MSB first.
  always @(negedge clk) begin
    if (!rst_n) begin
      rises_a = 0; falls_a = 0; w_a = '0;
    end else begin
      if (busy_a && !pb_a) falls_a = 0;
      if (!div_clk && pdiv_a) falls_a = falls_a + 1;
      if (sclk_a && !ps_a) begin
        if (rises_a == 0) cur_a.first = sdata_a;
        w_a = {w_a[14:0], sdata_a};
        rises_a = rises_a + 1;
        tot_rise_a = tot_rise_a + 1;
      end
      if (latch_a && !pl_a) begin
        cur_a.word = w_a; cur_a.rises = rises_a; cur_a.falls = falls_a;
        cur_a.t_rise = cyc; cur_a.llen = 0;
        tot_latch_a = tot_latch_a + 1;
      end
      if (latch_a) cur_a.llen = cur_a.llen + 1;
      if (!latch_a && pl_a) begin
        cur_a.busy_end = busy_a;
        got_a.push_back(cur_a);
        rises_a = 0; w_a = '0;
      end
    end
    pdiv_a = div_clk; ps_a = sclk_a; pl_a = latch_a; pb_a = busy_a;
  end

  // Wire-level receiver for instance B: first bit lands in bit 0.
  always @(negedge clk) begin
    if (!rst_n) begin
      rises_b = 0; falls_b = 0; w_b = '0;
    end else begin
      if (busy_b && !pb_b) falls_b = 0;
      if (!div_clk && pdiv_b) falls_b = falls_b + 1;
      if (sclk_b && !ps_b) begin
        if (rises_b == 0) cur_b.first = sdata_b;
        w_b = {sdata_b, w_b[15:1]};
        rises_b = rises_b + 1;
      end
      if (latch_b && !pl_b) begin
        cur_b.word = w_b; cur_b.rises = rises_b; cur_b.falls = falls_b;
        cur_b.t_rise = cyc; cur_b.llen = 0;
      end
      if (latch_b) cur_b.llen = cur_b.llen + 1;
      if (!latch_b && pl_b) begin
        cur_b.busy_end = busy_b;
        got_b.push_back(cur_b);
        rises_b = 0; w_b = '0;
      end
    end
    pdiv_b = div_clk; ps_b = sclk_b; pl_b = latch_b; pb_b = busy_b;
  end

  function automatic frame_t pop_frame(input bit sel);
    frame_t r;
    r.word = 'x; r.rises = -1; r.llen = -1; r.falls = -1;
    r.busy_end = 1'bx; r.first = 1'bx; r.t_rise = 0;
    if (sel) begin
      if (got_b.size() > 0) r = got_b.pop_front();
    end else begin
      if (got_a.size() > 0) r = got_a.pop_front();
    end
    return r;
  endfunction

  function automatic logic [15:0] pop_exp(input bit sel);
    logic [15:0] r;
    r = 'x;
    if (sel) begin
      if (exp_b.size() > 0) r = exp_b.pop_front();
    end else begin
      if (exp_a.size() > 0) r = exp_a.pop_front();
    end
    return r;
  endfunction

  task automatic wait_ready(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRAME_TMO; i++) begin
      @(negedge clk);
      if (sel ? ready_b : ready_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input bit sel, input logic [15:0] w, output bit ok);
    wait_ready(sel, ok);
    if (ok) begin
      if (sel) begin valid_b = 1'b1; data_b = w; end
      else     begin valid_a = 1'b1; data_a = w; end
      @(negedge clk);
      valid_a = 1'b0;
      valid_b = 1'b0;
    end
  endtask

  task automatic wait_frames(input bit sel, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < n * FRAME_TMO; i++) begin
      if ((sel ? got_b.size() : got_a.size()) >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bit ok;
    int base_r, base_l;
    logic [15:0] w;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready_a, ready_b} !== 2'b11) begin
      errors++; $display("FAIL reset_ready got=%b%b want=11", ready_a, ready_b);
    end
    checks++;
    if ({busy_a, sclk_a, sdata_a, latch_a, busy_b, sclk_b, sdata_b, latch_b} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got=%b%b%b%b_%b%b%b%b want=0000_0000",
                         busy_a, sclk_a, sdata_a, latch_a, busy_b, sclk_b, sdata_b, latch_b);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL reset_release got ready=%b busy=%b want ready=1 busy=0", ready_a, busy_a);
    end
    // Abort a frame while sclk is high and sdata carries a 1.
    w = 16'($urandom) | 16'h8000;
    send(1'b0, w, ok);
    ok = ok;
    for (int i = 0; i < 2 * FRAME_TMO && !sclk_a; i++) @(negedge clk);
    checks++;
    if (sclk_a !== 1'b1) begin
      errors++; $display("FAIL reset_reach_shift got sclk=%b want=1", sclk_a);
    end
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sclk_a, sdata_a, latch_a, busy_a, ready_a} !== 5'b00001) begin
      errors++; $display("FAIL reset_midframe got sclk,sdata,latch,busy,ready=%b%b%b%b%b want=00001",
                         sclk_a, sdata_a, latch_a, busy_a, ready_a);
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    base_r = tot_rise_a;
    base_l = tot_latch_a;
    repeat (3 * PERIOD) @(negedge clk);
    checks++;
    if (tot_rise_a != base_r) begin
      errors++; $display("FAIL reset_stray_sclk got=%0d rises want=0", tot_rise_a - base_r);
    end
    checks++;
    if (tot_latch_a != base_l || got_a.size() != 0) begin
      errors++; $display("FAIL reset_no_latch got=%0d latches want=0", tot_latch_a - base_l);
    end
  endtask

  task automatic test_basic();
    bit ok;
    frame_t f;
    logic [15:0] e;
    send(1'b0, 16'hA55A, ok);
    wait_frames(1'b0, 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got=%0d frames want=1", got_a.size()); end
    f = pop_frame(1'b0);
    e = pop_exp(1'b0);
    e = e;
    checks++;
    if (f.word !== 16'hA55A) begin errors++; $display("FAIL basic_word got=%h want=a55a", f.word); end
    checks++;
    if (f.rises != 16) begin errors++; $display("FAIL basic_rises got=%0d want=16", f.rises); end
    checks++;
    if (f.llen != PERIOD) begin errors++; $display("FAIL basic_latch_len got=%0d want=%0d", f.llen, PERIOD); end
    checks++;
    if (f.falls != 17) begin errors++; $display("FAIL basic_latch_start got=%0d falls want=17", f.falls); end
    checks++;
    if (f.busy_end !== 1'b1) begin errors++; $display("FAIL basic_gap_busy got=%b want=1", f.busy_end); end
  endtask

  task automatic test_busy_reject();
    bit ok;
    int nready;
    frame_t f;
    logic [15:0] e;
    wait_ready(1'b0, ok);
    valid_a = 1'b1;
    data_a  = 16'hA55A;
    @(negedge clk);
    data_a = 16'h1234;
    nready = 0;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME_TMO; i++) begin
      @(negedge clk);
      if (ready_a) nready++;
      else if (nready > 0) begin ok = 1'b1; break; end
    end
    valid_a = 1'b0;
    checks++;
    if (!ok || nready != 1) begin
      errors++; $display("FAIL busy_first_ready got=%0d ready cycles (reaccepted=%b) want=1", nready, ok);
    end
    wait_frames(1'b0, 2, ok);
    f = pop_frame(1'b0);
    e = pop_exp(1'b0);
    checks++;
    if (f.word !== 16'hA55A || e !== 16'hA55A) begin
      errors++; $display("FAIL busy_frame1 got=%h model=%h want=a55a", f.word, e);
    end
    f = pop_frame(1'b0);
    e = pop_exp(1'b0);
    checks++;
    if (f.word !== 16'h1234 || e !== 16'h1234) begin
      errors++; $display("FAIL busy_frame2 got=%h model=%h want=1234", f.word, e);
    end
  endtask

  task automatic test_lsb_first();
    bit ok;
    frame_t f;
    logic [15:0] e;
    send(1'b1, 16'h0001, ok);
    wait_frames(1'b1, 1, ok);
    f = pop_frame(1'b1);
    e = pop_exp(1'b1);
    e = e;
    checks++;
    if (f.first !== 1'b1) begin errors++; $display("FAIL lsb_first_bit got=%b want=1", f.first); end
    checks++;
    if (f.word !== 16'h0001) begin errors++; $display("FAIL lsb_word got=%h want=0001", f.word); end
    checks++;
    if (f.rises != 16 || f.llen != PERIOD || f.falls != 17) begin
      errors++; $display("FAIL lsb_timing got rises=%0d latch=%0d falls=%0d want 16/%0d/17",
                         f.rises, f.llen, f.falls, PERIOD);
    end
    checks++;
    if (f.busy_end !== 1'b0) begin errors++; $display("FAIL lsb_nogap_busy got=%b want=0", f.busy_end); end
  endtask

  task automatic test_random();
    bit ok;
    frame_t f;
    logic [15:0] e, w;
    for (int k = 0; k < 4; k++) begin
      w = 16'($urandom);
      send(k[0], w, ok);
      wait_frames(k[0], 1, ok);
      f = pop_frame(k[0]);
      e = pop_exp(k[0]);
      checks++;
      if (f.word !== w || e !== w || f.rises != 16 || f.llen != PERIOD) begin
        errors++; $display("FAIL random_%0d got=%h rises=%0d latch=%0d want=%h 16 %0d",
                           k, f.word, f.rises, f.llen, w, PERIOD);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    frame_t f;
    logic [15:0] e;
    longint t_prev, d;
    valid_a = 1'b1;
    data_a  = 16'($urandom);
    for (int i = 0; i < 5 * FRAME_TMO && got_a.size() < 3; i++) begin
      @(negedge clk);
      data_a = 16'($urandom);
    end
    valid_a = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME_TMO; i++) begin
      @(negedge clk);
      if (ready_a && got_a.size() == exp_a.size()) begin ok = 1'b1; break; end
    end
    n = got_a.size();
    checks++;
    if (!ok || n < 3) begin errors++; $display("FAIL b2b_frames got=%0d settled=%b want>=3", n, ok); end
    t_prev = 0;
    for (int i = 0; i < n; i++) begin
      f = pop_frame(1'b0);
      e = pop_exp(1'b0);
      checks++;
      if (f.word !== e || f.rises != 16) begin
        errors++; $display("FAIL b2b_word_%0d got=%h rises=%0d want=%h 16", i, f.word, f.rises, e);
      end
      if (i > 0) begin
        d = f.t_rise - t_prev;
        checks++;
        if (d != 18 * PERIOD && d != 19 * PERIOD) begin
          errors++; $display("FAIL b2b_spacing_%0d got=%0d want=%0d or %0d", i, d, 18 * PERIOD, 19 * PERIOD);
        end
      end
      t_prev = f.t_rise;
    end
  endtask

  task automatic test_stall();
    bit ok;
    int bad;
    frame_t f;
    logic [15:0] e, w;
    for (int i = 0; i < 2 * PERIOD && div_clk; i++) @(negedge clk);
    stall = 1'b1;
    w = 16'($urandom);
    send(1'b0, w, ok);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (busy_a !== 1'b1 || ready_a !== 1'b0 || sclk_a !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || !ok) begin
      errors++; $display("FAIL stall_hold got=%0d bad cycles (sent=%b) want=0", bad, ok);
    end
    stall = 1'b0;
    wait_frames(1'b0, 1, ok);
    f = pop_frame(1'b0);
    e = pop_exp(1'b0);
    checks++;
    if (f.word !== w || e !== w || f.rises != 16 || f.llen != PERIOD || f.falls != 17) begin
      errors++; $display("FAIL stall_resume got=%h rises=%0d latch=%0d falls=%0d want=%h 16 %0d 17",
                         f.word, f.rises, f.llen, f.falls, w, PERIOD);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_reject();
    test_lsb_first();
    test_random();
    test_back_to_back();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_ctrl_shifter
`default_nettype wire
